cache_dm_ctrl: RTL and testbench

- Clocked, parametrised direct-mapped cache controller between one CPU byte port and a line-wide memory port.
- Generalises the earlier combinational cache to configurable address width, line size and line count.
- Adds a registered request/done handshake, a memory req/ready handshake, and selectable write-through or write-back with dirty tracking.
- Adds saturating hit/miss statistics counters.

---
 rtl/cache_dm_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cache_dm_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_dm_ctrl.sv
// Direct-mapped cache controller between a CPU byte port and a line-wide memory port.
// Supports write-through or write-back with dirty tracking, and has saturating hit/miss counters.
module cache_dm_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_BYTES = 16,
  parameter int NUM_BLOCKS  = 4,
  parameter int WRITE_BACK  = 0,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_row,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [7:0]               in_write_data,
  output logic                     out_ready,
  output logic                     out_done,
  output logic                     hit_or_miss,
  output logic [7:0]               out_read_data,
  output logic                     mem_req,
  output logic                     mem_row,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [8*BLOCK_BYTES-1:0] mem_write_data,
  input  logic [8*BLOCK_BYTES-1:0] mem_read_data,
  input  logic                     mem_ready,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count
);
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_W  = $clog2(NUM_BLOCKS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = 8 * BLOCK_BYTES;

  typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE, S_WTHRU} state_t;

  state_t r_state, w_next;

  logic [LINE_W-1:0] r_data [NUM_BLOCKS];
  logic [TAG_W-1:0]  r_tag  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] r_valid, r_dirty;

  logic [ADDR_W-1:0] r_addr;
  logic              r_row, r_missed;
  logic [7:0]        r_wdata, r_rdata;
  logic              r_mem_req, r_mem_row;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_off;
  logic [LINE_W-1:0] w_line, w_upd_line;
  logic [7:0]        w_byte;
  logic              w_hit, w_done, w_launch, w_launch_row, w_fill, w_wr_hit, w_miss, w_mem_fin;
  logic [ADDR_W-1:0] w_launch_addr;
  logic [LINE_W-1:0] w_launch_data;

  assign w_off  = r_addr[OFF_W-1:0];
  assign w_idx  = r_addr[OFF_W+IDX_W-1:OFF_W];
  assign w_tag  = r_addr[ADDR_W-1:OFF_W+IDX_W];
  assign w_line = r_data[w_idx];
  assign w_byte = w_line[w_off*8 +: 8];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_mem_fin = r_mem_req & mem_ready;

  always_comb begin
    w_upd_line = w_line;
    w_upd_line[w_off*8 +: 8] = r_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_done        = 1'b0;
    w_launch      = 1'b0;
    w_launch_row  = 1'b0;
    w_launch_addr = '0;
    w_launch_data = '0;
    w_fill        = 1'b0;
    w_wr_hit      = 1'b0;
    w_miss        = 1'b0;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_COMPARE;
      S_COMPARE: begin
        if (w_hit) begin
          if (!r_row) begin
            w_done = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_wr_hit = 1'b1;
            if (WRITE_BACK != 0) begin
              w_done = 1'b1;
              w_next = S_IDLE;
            end else begin
              w_next        = S_WTHRU;
              w_launch      = 1'b1;
              w_launch_row  = 1'b1;
              w_launch_addr = {w_tag, w_idx, {OFF_W{1'b0}}};
              w_launch_data = w_upd_line;
            end
          end
        end else begin
          w_miss   = 1'b1;
          w_launch = 1'b1;
          if ((WRITE_BACK != 0) && r_valid[w_idx] && r_dirty[w_idx]) begin
            w_next        = S_WRITEBACK;
            w_launch_row  = 1'b1;
            w_launch_addr = {r_tag[w_idx], w_idx, {OFF_W{1'b0}}};
            w_launch_data = w_line;
          end else begin
            w_next        = S_ALLOCATE;
            w_launch_addr = {w_tag, w_idx, {OFF_W{1'b0}}};
          end
        end
      end
      S_WRITEBACK: if (w_mem_fin) w_next = S_ALLOCATE;
      S_ALLOCATE: begin
        // After a writeback, the request line idles for one cycle before the refill is issued.
        if (!r_mem_req) begin
          w_launch      = 1'b1;
          w_launch_addr = {w_tag, w_idx, {OFF_W{1'b0}}};
        end else if (mem_ready) begin
          w_fill = 1'b1;
          w_next = S_COMPARE;
        end
      end
      S_WTHRU: if (w_mem_fin) begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_hit) r_data[w_idx] <= w_upd_line;
    else if (!rst && w_fill) r_data[w_idx] <= mem_read_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_dirty     <= '0;
      r_addr      <= '0;
      r_row       <= 1'b0;
      r_wdata     <= '0;
      r_missed    <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_row   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) r_tag[i] <= '0;
    end else begin
      if (in_valid && r_state == S_IDLE) begin
        r_addr   <= in_addr;
        r_row    <= in_row;
        r_wdata  <= in_write_data;
        r_missed <= 1'b0;
      end
      if (w_miss) begin
        r_missed <= 1'b1;
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
      if (w_done && !r_missed && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_done && !r_row) r_rdata <= w_byte;
      if (w_wr_hit && WRITE_BACK != 0) r_dirty[w_idx] <= 1'b1;
      if (w_fill) begin
        r_tag[w_idx]   <= w_tag;
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
      if (w_launch) begin
        r_mem_req   <= 1'b1;
        r_mem_row   <= w_launch_row;
        r_mem_addr  <= w_launch_addr;
        r_mem_wdata <= w_launch_data;
      end else if (w_mem_fin) begin
        r_mem_req <= 1'b0;
      end
    end
  end

  assign out_ready      = (r_state == S_IDLE);
  assign out_done       = w_done;
  assign hit_or_miss    = w_done & ~r_missed;
  assign out_read_data  = (w_done && !r_row) ? w_byte : r_rdata;
  assign mem_req        = r_mem_req;
  assign mem_row        = r_mem_row;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign hit_count      = r_hit_cnt;
  assign miss_count     = r_miss_cnt;
endmodule

// File: tb/tb_cache_dm_ctrl.sv
// Directed bench for cache_dm_ctrl: a write-through instance and a write-back instance
// (2-bit counters to reach saturation) share the stimulus, selected by sel.
module tb_cache_dm_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic in_valid = 1'b0, in_row = 1'b0, mem_ready = 1'b0;
  logic [9:0] in_addr = '0;
  logic [7:0] in_wdata = '0;
  logic [127:0] mem_rdata = '0;

  logic a_ready, a_done, a_hom, a_req, a_row;
  logic [7:0] a_rdata;
  logic [9:0] a_addr;
  logic [127:0] a_wdata;
  logic [15:0] a_hit, a_miss;
  logic b_ready, b_done, b_hom, b_req, b_row;
  logic [7:0] b_rdata;
  logic [9:0] b_addr;
  logic [127:0] b_wdata;
  logic [1:0] b_hit, b_miss;

  wire a_valid = in_valid & ~sel;
  wire b_valid = in_valid & sel;
  wire a_mrdy  = mem_ready & ~sel;
  wire b_mrdy  = mem_ready & sel;

  cache_dm_ctrl #(.WRITE_BACK(0)) u_wt (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_row(in_row), .in_addr(in_addr),
    .in_write_data(in_wdata), .out_ready(a_ready), .out_done(a_done), .hit_or_miss(a_hom),
    .out_read_data(a_rdata), .mem_req(a_req), .mem_row(a_row), .mem_addr(a_addr),
    .mem_write_data(a_wdata), .mem_read_data(mem_rdata), .mem_ready(a_mrdy),
    .hit_count(a_hit), .miss_count(a_miss));

  cache_dm_ctrl #(.WRITE_BACK(1), .CNT_W(2)) u_wb (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_row(in_row), .in_addr(in_addr),
    .in_write_data(in_wdata), .out_ready(b_ready), .out_done(b_done), .hit_or_miss(b_hom),
    .out_read_data(b_rdata), .mem_req(b_req), .mem_row(b_row), .mem_addr(b_addr),
    .mem_write_data(b_wdata), .mem_read_data(mem_rdata), .mem_ready(b_mrdy),
    .hit_count(b_hit), .miss_count(b_miss));

  wire         m_ready = sel ? b_ready : a_ready;
  wire         m_done  = sel ? b_done  : a_done;
  wire         m_hom   = sel ? b_hom   : a_hom;
  wire         m_req   = sel ? b_req   : a_req;
  wire         m_row   = sel ? b_row   : a_row;
  wire [7:0]   m_rdata = sel ? b_rdata : a_rdata;
  wire [9:0]   m_addr  = sel ? b_addr  : a_addr;
  wire [127:0] m_wdata = sel ? b_wdata : a_wdata;
  wire [15:0]  m_hit   = sel ? {14'b0, b_hit}  : a_hit;
  wire [15:0]  m_miss  = sel ? {14'b0, b_miss} : a_miss;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [127:0] line0, line1, l0_wb, l0_wt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic req(input logic row, input logic [9:0] addr, input logic [7:0] data);
    in_valid = 1'b1; in_row = row; in_addr = addr; in_wdata = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic mem_give(input logic [127:0] line);
    mem_rdata = line; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      line0[8*k +: 8] = 8'h10 + 8'(k);
      line1[8*k +: 8] = 8'h50 + 8'(k);
    end
    line0[8*5 +: 8] = 8'hA5;
    line1[8*2 +: 8] = 8'h5E;
    l0_wb = line0; l0_wb[8*2 +: 8] = 8'h3C;
    l0_wt = line0; l0_wt[8*3 +: 8] = 8'h77;

    // ---- write-through instance ----
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 128'(m_ready), 128'd1);
    chk("rst_done", 128'(m_done), 128'd0);
    chk("rst_req", 128'(m_req), 128'd0);
    chk("rst_rdata", 128'(m_rdata), 128'h0);
    chk("rst_maddr", 128'(m_addr), 128'h0);
    chk("rst_cnt", 128'({m_hit, m_miss}), 128'h0);

    req(1'b0, 10'h015, 8'h00);
    chk("rd015_cmp_done", 128'(m_done), 128'd0);
    tick();
    chk("rd015_alloc_req", 128'({m_req, m_row, m_addr}), 128'({1'b1, 1'b0, 10'h010}));
    mem_give(line0);
    chk("rd015_done", 128'({m_done, m_hom, m_rdata}), 128'({1'b1, 1'b0, 8'hA5}));
    chk("rd015_miss_cnt", 128'(m_miss), 128'd1);
    chk("rd015_req_drop", 128'(m_req), 128'd0);
    tick();
    chk("rd015_hold", 128'({m_ready, m_rdata}), 128'({1'b1, 8'hA5}));

    req(1'b0, 10'h01A, 8'h00);
    chk("rd01A_hit", 128'({m_done, m_hom, m_rdata, m_req}), 128'({1'b1, 1'b1, 8'h1A, 1'b0}));
    tick();
    chk("rd01A_cnt", 128'({m_ready, m_hit}), 128'({1'b1, 16'd1}));

    req(1'b1, 10'h013, 8'h77);
    chk("wr013_cmp_done", 128'(m_done), 128'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("wthru_req", 128'({m_req, m_row, m_addr}), 128'({1'b1, 1'b1, 10'h010}));
      chk("wthru_data", m_wdata, l0_wt);
      chk("wthru_busy", 128'({m_ready, m_done}), 128'd0);
      in_valid = (i == 2); in_row = 1'b0; in_addr = 10'h200;
      tick();
    end
    in_valid = 1'b0;
    mem_ready = 1'b1; #1;
    chk("wthru_done", 128'({m_done, m_hom}), 128'({1'b1, 1'b1}));
    tick();
    mem_ready = 1'b0;
    chk("wthru_after", 128'({m_req, m_ready, m_done, m_hit}), 128'({1'b0, 1'b1, 1'b0, 16'd2}));
    tick();
    chk("dropped_req", 128'({m_ready, m_done}), 128'({1'b1, 1'b0}));

    req(1'b0, 10'h013, 8'h00);
    chk("rd013_hit", 128'({m_done, m_hom, m_rdata}), 128'({1'b1, 1'b1, 8'h77}));
    tick();

    req(1'b0, 10'h215, 8'h00);
    tick();
    chk("rd215_alloc", 128'({m_req, m_row, m_addr}), 128'({1'b1, 1'b0, 10'h210}));
    rst = 1'b1; mem_rdata = line1; mem_ready = 1'b1;
    tick();
    rst = 1'b0; mem_ready = 1'b0;
    chk("abort_state", 128'({m_req, m_ready, m_hit, m_miss}), 128'({1'b0, 1'b1, 16'd0, 16'd0}));
    req(1'b0, 10'h215, 8'h00);
    chk("reread_miss", 128'(m_done), 128'd0);
    tick();
    chk("reread_alloc", 128'({m_req, m_addr}), 128'({1'b1, 10'h210}));
    mem_give(line1);
    chk("reread_done", 128'({m_done, m_hom, m_rdata}), 128'({1'b1, 1'b0, 8'h55}));
    tick();

    // ---- write-back instance ----
    sel = 1'b1; #1;
    req(1'b0, 10'h015, 8'h00);
    tick();
    chk("wb_rd015_alloc", 128'({m_req, m_row, m_addr}), 128'({1'b1, 1'b0, 10'h010}));
    mem_give(line0);
    chk("wb_rd015_done", 128'({m_done, m_hom, m_rdata}), 128'({1'b1, 1'b0, 8'hA5}));
    tick();

    req(1'b1, 10'h012, 8'h3C);
    chk("wb_wr012_hit", 128'({m_done, m_hom, m_req}), 128'({1'b1, 1'b1, 1'b0}));
    tick();
    chk("wb_hit_cnt", 128'(m_hit), 128'd1);

    req(1'b0, 10'h112, 8'h00);
    chk("wb_rd112_cmp", 128'(m_done), 128'd0);
    tick();
    chk("wb_evict_req", 128'({m_req, m_row, m_addr}), 128'({1'b1, 1'b1, 10'h010}));
    chk("wb_evict_data", m_wdata, l0_wb);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("wb_req_gap", 128'(m_req), 128'd0);
    tick();
    chk("wb_rd112_alloc", 128'({m_req, m_row, m_addr}), 128'({1'b1, 1'b0, 10'h110}));
    mem_give(line1);
    chk("wb_rd112_done", 128'({m_done, m_hom, m_rdata, m_miss}), 128'({1'b1, 1'b0, 8'h5E, 16'd2}));
    tick();

    req(1'b0, 10'h012, 8'h00);
    tick();
    chk("wb_clean_alloc", 128'({m_req, m_row, m_addr}), 128'({1'b1, 1'b0, 10'h010}));
    mem_give(l0_wb);
    chk("wb_rd012_done", 128'({m_done, m_rdata, m_miss}), 128'({1'b1, 8'h3C, 16'd3}));
    tick();

    req(1'b0, 10'h215, 8'h00);
    tick();
    chk("wb_rd215_alloc", 128'({m_req, m_row, m_addr}), 128'({1'b1, 1'b0, 10'h210}));
    mem_give(line1);
    chk("wb_miss_sat", 128'({m_done, m_miss, m_hit}), 128'({1'b1, 16'd3, 16'd1}));
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
